extbus_resp: RTL and testbench

EXTBUS_RESP -- requirements
Module: extbus_resp

---
 rtl/extbus_resp.sv | 189 ++++++++++++++++++
 tb/tb_extbus_resp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/extbus_resp.sv
// Doubleword-wide external bus responder backed by a local RAM.
// Accepts single-beat and 2-beat writes and returns 1/2/4-beat read replies after a fixed latency.
module extbus_resp #(
  parameter int ADDR_BITS = 15,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] extaddr,
  input  logic [63:0] extwdata,
  input  logic [4:0]  extsz,
  input  logic        extreq,
  input  logic        extwr,
  input  logic        extsrc,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror
);

  localparam int DW_BITS = ADDR_BITS - 3;
  localparam int DEPTH   = 1 << DW_BITS;

  typedef enum logic [1:0] {IDLE, WR2, WAIT, REPLY} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           beat_q, beat_d;
  logic [1:0]           last_q, last_d;
  logic [DW_BITS-1:0]   dw_q, dw_d;
  logic                 err_q, err_d;
  logic                 extrdy_q, extrdy_d;
  logic                 extreply_q, extreply_d;
  logic                 extreplyto_q, extreplyto_d;
  logic [63:0]          extrdata_q, extrdata_d;
  logic                 exterror_q, exterror_d;

  logic [63:0]          mem [DEPTH];
  logic                 mem_we;
  logic [DW_BITS-1:0]   mem_widx;
  logic [63:0]          mem_wdata;
  logic [DW_BITS-1:0]   rd_idx, beat_dw, req_dw;
  logic [63:0]          rd_word, merged;
  logic [1:0]           nxt_beat;
  logic                 oor, sz_single, sz_legal, accept;

  // Request decode and the shared RAM read port (write merge in IDLE, reply beats otherwise).
  always_comb begin
    req_dw    = extaddr[ADDR_BITS-1:3];
    oor       = (extaddr >> ADDR_BITS) != 32'd0;
    sz_single = (extsz[4:3] == 2'b00);
    sz_legal  = sz_single || (extsz == 5'd15) || (extsz == 5'd31);
    accept    = extreq && extrdy_q;
    nxt_beat  = (state_q == REPLY) ? beat_q + 2'd1 : 2'd0;
    case (last_q)
      2'd1:    beat_dw = dw_q ^ {{(DW_BITS-1){1'b0}}, nxt_beat[0]};
      2'd3:    beat_dw = {dw_q[DW_BITS-1:2], nxt_beat};
      default: beat_dw = dw_q;
    endcase
    rd_idx  = (state_q == IDLE) ? req_dw : beat_dw;
    rd_word = mem[rd_idx];
  end

  // Big-endian lane merge: lane k is bits [63-8k -: 8]; the first lane gets the MSB of the data.
  always_comb begin
    merged = rd_word;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(extaddr[2:0]) && k <= int'(extaddr[2:0]) + int'(extsz[2:0]))
        merged[63-8*k -: 8] = extwdata[8*(int'(extsz[2:0]) + int'(extaddr[2:0]) - k) +: 8];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    last_d       = last_q;
    dw_d         = dw_q;
    err_d        = err_q;
    extreplyto_d = extreplyto_q;
    extrdy_d     = 1'b0;
    extreply_d   = 1'b0;
    extrdata_d   = '0;
    exterror_d   = 1'b0;
    mem_we       = 1'b0;
    mem_widx     = rd_idx;
    mem_wdata    = merged;
    case (state_q)
      IDLE: begin
        extrdy_d = 1'b1;
        if (accept && extwr) begin
          if (extsz == 5'd15) begin
            state_d   = WR2;
            dw_d      = {req_dw[DW_BITS-1:1], 1'b0};
            err_d     = oor;
            mem_we    = !oor;
            mem_widx  = {req_dw[DW_BITS-1:1], 1'b0};
            mem_wdata = extwdata;
          end else if (sz_single && !oor) begin
            mem_we = 1'b1;
          end
        end else if (accept) begin
          state_d      = WAIT;
          extrdy_d     = 1'b0;
          cnt_d        = 4'(LATENCY - 1);
          dw_d         = req_dw;
          err_d        = oor || !sz_legal;
          last_d       = !sz_legal ? 2'd0 : (extsz == 5'd15) ? 2'd1 : (extsz == 5'd31) ? 2'd3 : 2'd0;
          extreplyto_d = extsrc;
        end
      end
      WR2: begin
        extrdy_d = 1'b1;
        if (accept) begin
          state_d   = IDLE;
          mem_we    = !err_q;
          mem_widx  = {dw_q[DW_BITS-1:1], 1'b1};
          mem_wdata = extwdata;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = REPLY;
          beat_d     = 2'd0;
          extreply_d = 1'b1;
          exterror_d = err_q;
          extrdata_d = err_q ? 64'd0 : rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REPLY: begin
        if (beat_q == last_q) begin
          state_d  = IDLE;
          extrdy_d = 1'b1;
        end else begin
          beat_d     = nxt_beat;
          extreply_d = 1'b1;
          exterror_d = err_q;
          extrdata_d = err_q ? 64'd0 : rd_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      last_q       <= '0;
      dw_q         <= '0;
      err_q        <= 1'b0;
      extrdy_q     <= 1'b0;
      extreply_q   <= 1'b0;
      extreplyto_q <= 1'b0;
      extrdata_q   <= '0;
      exterror_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      dw_q         <= dw_d;
      err_q        <= err_d;
      extrdy_q     <= extrdy_d;
      extreply_q   <= extreply_d;
      extreplyto_q <= extreplyto_d;
      extrdata_q   <= extrdata_d;
      exterror_q   <= exterror_d;
    end
  end

  // NOTE: the backing store has no reset; its contents must survive rstn.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign extrdy     = extrdy_q;
  assign extreply   = extreply_q;
  assign extreplyto = extreplyto_q;
  assign extrdata   = extrdata_q;
  assign exterror   = exterror_q;

endmodule

// File: tb/tb_extbus_resp.sv
// Self-checking bench for extbus_resp: directed scenarios plus random traffic
// compared against a byte-addressed memory model.
module tb_extbus_resp;
  localparam int ADDR_BITS = 15;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] extaddr = '0;
  logic [63:0] extwdata = '0;
  logic [4:0]  extsz = '0;
  logic        extreq = 1'b0;
  logic        extwr = 1'b0;
  logic        extsrc = 1'b0;
  logic        extrdy, extreply, extreplyto, exterror;
  logic [63:0] extrdata;

  int checks = 0;
  int failures = 0;
  logic [7:0] mb [0:32767];

  always #5 clk = ~clk;

  extbus_resp #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rstn(rstn), .extaddr(extaddr), .extwdata(extwdata), .extsz(extsz),
    .extreq(extreq), .extwr(extwr), .extsrc(extsrc), .extrdy(extrdy), .extreply(extreply),
    .extreplyto(extreplyto), .extrdata(extrdata), .exterror(exterror)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (extrdy !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check(tag, {63'd0, extrdy}, 64'd1);
  endtask

  // Model: big-endian doubleword built from eight bytes starting at the aligned address.
  function automatic logic [63:0] dw_at(input int a);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[55:0], mb[(a & ~7) + i]};
    return v;
  endfunction

  function automatic void model_write(input int a, input int sz, input logic [63:0] w0,
                                      input logic [63:0] w1);
    if (a >= (1 << ADDR_BITS)) return;
    if (sz <= 7) begin
      for (int j = 0; j <= sz; j++)
        if ((a % 8) + j < 8) mb[(a & ~7) + (a % 8) + j] = w0[8*(sz-j) +: 8];
    end else if (sz == 15) begin
      for (int i = 0; i < 8; i++) begin
        mb[(a & ~15) + i]     = w0[63-8*i -: 8];
        mb[(a & ~15) + 8 + i] = w1[63-8*i -: 8];
      end
    end
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [4:0] sz, input logic [63:0] w0,
                          input logic [63:0] w1);
    wait_rdy("wr_rdy");
    extreq = 1'b1; extwr = 1'b1; extaddr = a; extsz = sz; extwdata = w0;
    step();
    if (sz == 5'd15) begin
      check("wr2_rdy", {63'd0, extrdy}, 64'd1);
      extaddr = $urandom; extsz = 5'($urandom); extwdata = w1;
      step();
    end
    extreq = 1'b0; extwr = 1'b0;
    check("wr_no_reply", {63'd0, extreply}, 64'd0);
    check("wr_back_idle", {63'd0, extrdy}, 64'd1);
    model_write(int'(a), int'(sz), w0, w1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [4:0] sz, input logic src);
    int  ai = int'(a);
    int  s = int'(sz);
    bit  legal = (s <= 7) || (s == 15) || (s == 31);
    bit  err = !legal || (ai >= (1 << ADDR_BITS));
    int  nb = !legal ? 1 : (s == 15) ? 2 : (s == 31) ? 4 : 1;
    int  ba;
    wait_rdy("rd_rdy");
    extreq = 1'b1; extwr = 1'b0; extaddr = a; extsz = sz; extsrc = src;
    step();
    extreq = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      check("rd_wait_rdy", {63'd0, extrdy}, 64'd0);
      check("rd_wait_noreply", {63'd0, extreply}, 64'd0);
      step();
    end
    for (int b = 0; b < nb; b++) begin
      if (s == 31 && legal)      ba = (ai & ~31) + 8*b;
      else if (s == 15 && b == 1) ba = (ai & ~7) ^ 8;
      else                        ba = ai & ~7;
      check("rd_reply", {63'd0, extreply}, 64'd1);
      check("rd_replyto", {63'd0, extreplyto}, {63'd0, src});
      check("rd_error", {63'd0, exterror}, {63'd0, err});
      check("rd_rdy_low", {63'd0, extrdy}, 64'd0);
      check("rd_data", extrdata, err ? 64'd0 : dw_at(ba));
      step();
    end
    check("rd_end_reply", {63'd0, extreply}, 64'd0);
    check("rd_end_data", extrdata, 64'd0);
    check("rd_end_error", {63'd0, exterror}, 64'd0);
    check("rd_end_rdy", {63'd0, extrdy}, 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [4:0]  sz;
    int          n;

    // Reset state
    repeat (3) step();
    check("rst_rdy", {63'd0, extrdy}, 64'd0);
    check("rst_reply", {63'd0, extreply}, 64'd0);
    check("rst_replyto", {63'd0, extreplyto}, 64'd0);
    check("rst_data", extrdata, 64'd0);
    check("rst_error", {63'd0, exterror}, 64'd0);
    rstn = 1'b1;
    check("rst_rdy_before_edge", {63'd0, extrdy}, 64'd0);
    step();
    check("rst_rdy_rise", {63'd0, extrdy}, 64'd1);

    // Preload 0x000-0x1FF so every model byte is known
    for (int i = 0; i < 32; i++)
      do_write(32'(i*16), 5'd15, {$urandom, $urandom}, {$urandom, $urandom});

    // Byte write, then full-doubleword read
    do_write(32'h13, 5'd0, 64'hAB, 64'd0);
    do_read(32'h10, 5'd7, 1'b0);

    // 16-byte read wraps within the aligned 16-byte block
    do_read(32'h28, 5'd15, 1'b1);

    // Two-beat write followed by a 32-byte block read
    do_write(32'h40, 5'd15, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    do_read(32'h44, 5'd31, 1'b0);

    // Out-of-range accesses
    do_read(32'h8000, 5'd31, 1'b1);
    do_write(32'h8010, 5'd7, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
    do_write(32'h8020, 5'd15, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    do_read(32'h10, 5'd7, 1'b0);
    do_read(32'h20, 5'd15, 1'b1);

    // Illegal sizes
    do_read(32'h30, 5'd9, 1'b1);
    do_write(32'h20, 5'd20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    do_read(32'h20, 5'd7, 1'b1);

    // Multi-byte write that runs off the end of the doubleword
    do_write(32'h36, 5'd5, 64'h0000_A1A2_A3A4_A5A6, 64'd0);
    do_read(32'h30, 5'd3, 1'b0);

    // Reset during the second beat of a 32-byte reply
    wait_rdy("rr_rdy");
    extreq = 1'b1; extwr = 1'b0; extaddr = 32'h60; extsz = 5'd31; extsrc = 1'b1;
    step();
    extreq = 1'b0;
    n = 0;
    while (extreply !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("rr_first_beat", {63'd0, extreply}, 64'd1);
    step();
    check("rr_second_beat", {63'd0, extreply}, 64'd1);
    #1 rstn = 1'b0;
    #1;
    check("rr_abort_reply", {63'd0, extreply}, 64'd0);
    check("rr_abort_data", extrdata, 64'd0);
    check("rr_abort_rdy", {63'd0, extrdy}, 64'd0);
    step();
    rstn = 1'b1;
    check("rr_rdy_held", {63'd0, extrdy}, 64'd0);
    step();
    check("rr_rdy_after", {63'd0, extrdy}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      check("rr_no_residual", {63'd0, extreply}, 64'd0);
      step();
    end
    do_read(32'h40, 5'd15, 1'b0);
    do_read(32'h60, 5'd31, 1'b1);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 'h1FF));
      if ($urandom_range(0, 9) == 9) a = a | 32'h8000;
      case ($urandom_range(0, 11))
        8:       sz = 5'd15;
        9:       sz = 5'd31;
        10:      sz = 5'($urandom_range(8, 14));
        11:      sz = 5'($urandom_range(16, 30));
        default: sz = 5'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, sz, {$urandom, $urandom}, {$urandom, $urandom});
      else
        do_read(a, sz, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
